// File: rtl/counter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | counter_pkg : shared debounce FSM encoding and timing constants       |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
package counter_pkg;

    // 10 ms of stable input at 50 MHz
    localparam int DEBOUNCE_10MS = 500000;

    typedef enum logic [1:0] {
        IDLE_OFF = 2'b00,
        WAIT_ON  = 2'b01,
        IDLE_ON  = 2'b10,
        WAIT_OFF = 2'b11
    } db_state_e;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/input_conditioner_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | input_conditioner_if : raw keys in, debounced level/pulses/toggle out |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface input_conditioner_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] raw;     // active-low raw keys
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] press;
    logic [WIDTH-1:0] rls;
    logic [WIDTH-1:0] toggle;

    modport master (output raw, input level, input press, input rls, input toggle);
    modport slave  (input raw, output level, output press, output rls, output toggle);
endinterface : input_conditioner_if
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | debounce_channel : synchronizer + 4-state debounce FSM for one key    |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module debounce_channel
    import counter_pkg::*;
#(
    parameter int   DebounceCycles = DEBOUNCE_10MS,
    parameter logic ToggleInit     = 1'b0
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input_conditioner_if.slave bus
);

    localparam int             CntW   = $clog2(DebounceCycles + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles);

    logic [1:0]      sync_q, sync_d;
    db_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic            toggle_q, toggle_d;
    logic            s;

    // Reset value 1 = key released, so a held key is seen as a fresh press
    assign sync_d = {sync_q[0], bus.raw};
    assign s      = ~sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            state_q <= IDLE_OFF;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter only advances below CntMax, so it can never wrap
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            IDLE_OFF: begin
                if (s) begin
                    state_d = WAIT_ON;
                    cnt_d   = CntW'(1);
                end
            end
            WAIT_ON: begin
                if (!s)                   state_d = IDLE_OFF;
                else if (cnt_q == CntMax) state_d = IDLE_ON;
                else                      cnt_d   = cnt_q + 1'b1;
            end
            IDLE_ON: begin
                if (!s) begin
                    state_d = WAIT_OFF;
                    cnt_d   = CntW'(1);
                end
            end
            WAIT_OFF: begin
                if (s)                    state_d = IDLE_ON;
                else if (cnt_q == CntMax) state_d = IDLE_OFF;
                else                      cnt_d   = cnt_q + 1'b1;
            end
            default: begin
                state_d = IDLE_OFF;
            end
        endcase
    end

    always_comb begin
        press_d   = (state_q == WAIT_ON)  && (state_d == IDLE_ON);
        release_d = (state_q == WAIT_OFF) && (state_d == IDLE_OFF);
        level_d   = press_d | (level_q & ~release_d);
        toggle_d  = toggle_q ^ press_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            toggle_q  <= ToggleInit;
        end else begin
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            toggle_q  <= toggle_d;
        end
    end

    assign bus.level  = level_q;
    assign bus.press  = press_q;
    assign bus.rls    = release_q;
    assign bus.toggle = toggle_q;

endmodule : debounce_channel
`default_nettype wire

// File: rtl/input_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | input_conditioner : bank of independent debounced key channels        |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module input_conditioner
    import counter_pkg::*;
#(
    parameter int                  Channels       = 5,
    parameter int                  DebounceCycles = DEBOUNCE_10MS,
    parameter logic [Channels-1:0] ToggleInit     = '0
) (
    input  wire logic                i_clock_50mhz,
    input  wire logic                i_reset,
    input  wire logic [Channels-1:0] i_raw,
    output logic      [Channels-1:0] o_level,
    output logic      [Channels-1:0] o_press,
    output logic      [Channels-1:0] o_release,
    output logic      [Channels-1:0] o_toggle
);

    for (genvar g = 0; g < Channels; g++) begin : g_channel
        input_conditioner_if #(.WIDTH(1)) u_ch_if ();

        assign u_ch_if.raw  = i_raw[g];
        assign o_level[g]   = u_ch_if.level;
        assign o_press[g]   = u_ch_if.press;
        assign o_release[g] = u_ch_if.rls;
        assign o_toggle[g]  = u_ch_if.toggle;

        debounce_channel #(
            .DebounceCycles (DebounceCycles),
            .ToggleInit     (ToggleInit[g])
        ) u_channel (
            .clk   (i_clock_50mhz),
            .rst_n (i_reset),
            .bus   (u_ch_if.slave)
        );
    end

endmodule : input_conditioner
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_input_conditioner : directed vector bench, DebounceCycles=4, 5 ch  |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_input_conditioner;

    localparam int         CH  = 5;
    localparam int         DB  = 4;
    localparam logic [4:0] TI  = 5'b00000;

    logic clk;
    logic rst_n;
    int   ncmp;
    int   nfail;
    int   npress0;
    int   nrel0;
    int   noverlap;
    logic mon_en;

    input_conditioner_if #(.WIDTH(CH)) u_bus ();

    input_conditioner #(
        .Channels       (CH),
        .DebounceCycles (DB),
        .ToggleInit     (TI)
    ) u_dut (
        .i_clock_50mhz (clk),
        .i_reset       (rst_n),
        .i_raw         (u_bus.raw),
        .o_level       (u_bus.level),
        .o_press       (u_bus.press),
        .o_release     (u_bus.rls),
        .o_toggle      (u_bus.toggle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] raw;
        int         ticks;
        logic [4:0] lvl;
        logic [4:0] prs;
        logic [4:0] rls;
        logic [4:0] tog;
    } vec_t;

    vec_t vecs [23];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Pulse counting for the repeated press/release run; overlap watched always
    always @(negedge clk) begin
        if (rst_n) begin
            if ((u_bus.press & u_bus.rls) != '0) noverlap++;
            if (mon_en && u_bus.press[0]) npress0++;
            if (mon_en && u_bus.rls[0])   nrel0++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ncmp = 0; nfail = 0; npress0 = 0; nrel0 = 0; noverlap = 0; mon_en = 1'b0;
        //             raw      tk  level     press     release   toggle
        vecs[0]  = '{5'b11110,  6, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
        vecs[1]  = '{5'b11110,  1, 5'b00001, 5'b00001, 5'b00000, 5'b00001};
        vecs[2]  = '{5'b11110, 13, 5'b00001, 5'b00000, 5'b00000, 5'b00001};
        vecs[3]  = '{5'b11111,  6, 5'b00001, 5'b00000, 5'b00000, 5'b00001};
        vecs[4]  = '{5'b11111,  1, 5'b00000, 5'b00000, 5'b00001, 5'b00001};
        vecs[5]  = '{5'b11111,  1, 5'b00000, 5'b00000, 5'b00000, 5'b00001};
        vecs[6]  = '{5'b01110,  6, 5'b00000, 5'b00000, 5'b00000, 5'b00001};
        vecs[7]  = '{5'b01110,  1, 5'b10001, 5'b10001, 5'b00000, 5'b10000};
        vecs[8]  = '{5'b11111,  6, 5'b10001, 5'b00000, 5'b00000, 5'b10000};
        vecs[9]  = '{5'b11111,  1, 5'b00000, 5'b00000, 5'b10001, 5'b10000};
        vecs[10] = '{5'b11111,  1, 5'b00000, 5'b00000, 5'b00000, 5'b10000};
        vecs[11] = '{5'b11011,  7, 5'b00100, 5'b00100, 5'b00000, 5'b10100};
        vecs[12] = '{5'b11011, 13, 5'b00100, 5'b00000, 5'b00000, 5'b10100};
        vecs[13] = '{5'b11111,  7, 5'b00000, 5'b00000, 5'b00100, 5'b10100};
        vecs[14] = '{5'b11111,  1, 5'b00000, 5'b00000, 5'b00000, 5'b10100};
        vecs[15] = '{5'b01111,  4, 5'b00000, 5'b00000, 5'b00000, 5'b10100};
        vecs[16] = '{5'b11111,  4, 5'b00000, 5'b00000, 5'b00000, 5'b10100};
        vecs[17] = '{5'b11111,  6, 5'b00000, 5'b00000, 5'b00000, 5'b10100};
        vecs[18] = '{5'b01111,  5, 5'b00000, 5'b00000, 5'b00000, 5'b10100};
        vecs[19] = '{5'b11111,  2, 5'b10000, 5'b10000, 5'b00000, 5'b00100};
        vecs[20] = '{5'b11111,  4, 5'b10000, 5'b00000, 5'b00000, 5'b00100};
        vecs[21] = '{5'b11111,  1, 5'b00000, 5'b00000, 5'b10000, 5'b00100};
        vecs[22] = '{5'b11111,  1, 5'b00000, 5'b00000, 5'b00000, 5'b00100};

        rst_n     = 1'b0;
        u_bus.raw = 5'b11111;
        #23;
        check("reset_level",   u_bus.level,  5'b00000);
        check("reset_press",   u_bus.press,  5'b00000);
        check("reset_release", u_bus.rls,    5'b00000);
        check("reset_toggle",  u_bus.toggle, TI);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) tick();

        // Channel 1 held for only 3 cycles must leave no trace
        u_bus.raw = 5'b11101;
        for (int i = 0; i < 13; i++) begin
            if (i == 3) u_bus.raw = 5'b11111;
            tick();
            check("short_pulse_ch1", {2'b00, u_bus.level[1], u_bus.press[1], u_bus.toggle[1]}, 5'b00000);
        end

        for (int v = 0; v < 23; v++) begin
            u_bus.raw = vecs[v].raw;
            repeat (vecs[v].ticks) tick();
            check($sformatf("vec%0d_level", v),   u_bus.level,  vecs[v].lvl);
            check($sformatf("vec%0d_press", v),   u_bus.press,  vecs[v].prs);
            check($sformatf("vec%0d_release", v), u_bus.rls,    vecs[v].rls);
            check($sformatf("vec%0d_toggle", v),  u_bus.toggle, vecs[v].tog);
        end

        // Reset two cycles into WAIT_ON on channel 3, key still held afterwards
        u_bus.raw = 5'b10111;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("pre_reset_press", u_bus.press, 5'b00000);
        end
        rst_n = 1'b0;
        #1;
        check("in_reset_toggle", u_bus.toggle, TI);
        check("in_reset_level",  u_bus.level,  5'b00000);
        repeat (2) tick();
        check("in_reset_press",  u_bus.press,  5'b00000);
        rst_n = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check($sformatf("post_reset_press_e%0d", i), u_bus.press, (i == 7) ? 5'b01000 : 5'b00000);
        end
        check("post_reset_toggle", u_bus.toggle, 5'b01000);
        u_bus.raw = 5'b11111;
        repeat (10) tick();
        check("post_reset_level", u_bus.level, 5'b00000);

        // Three press/release rounds on channel 0
        mon_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            u_bus.raw = 5'b11110;
            repeat (7) tick();
            check($sformatf("round%0d_press", k),  u_bus.press, 5'b00001);
            check($sformatf("round%0d_toggle0", k), {4'b0000, u_bus.toggle[0]}, (k % 2 == 0) ? 5'b00001 : 5'b00000);
            repeat (3) tick();
            u_bus.raw = 5'b11111;
            repeat (7) tick();
            check($sformatf("round%0d_release", k), u_bus.rls, 5'b00001);
            repeat (3) tick();
        end
        mon_en = 1'b0;
        check("press0_count",   5'(npress0),  5'd3);
        check("release0_count", 5'(nrel0),    5'd3);
        check("overlap_count",  5'(noverlap), 5'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule : tb_input_conditioner
`default_nettype wire
